// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding the UART transmit core through its tx_req/tx_busy handshake.
// Optional `UART_TXQ_FLUSH_EN adds a synchronous flush input.
module uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr,
  input  logic          run,
  output logic          tx_req,
  output logic [7:0]    tx_data,
  input  logic          tx_busy
`ifdef UART_TXQ_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    tmo_cnt;
  logic          flush_i;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;
  logic [AW:0]   level_nxt;

  // Fullness uses the registered (pre-edge) flags, so a same-cycle pop never rescues a push.
  always_comb begin
`ifdef UART_TXQ_FLUSH_EN
    flush_i = flush;
`else
    flush_i = 1'b0;
`endif
    do_push   = wr_en && !full && !flush_i;
    ovf_set   = wr_en && full && !flush_i;
    do_pop    = (state == IDLE) && !empty && run && !tx_busy && !flush_i;
    level_nxt = level;
    if (flush_i)
      level_nxt = '0;
    else if (do_push && !do_pop)
      level_nxt = level + LVL_ONE;
    else if (!do_push && do_pop)
      level_nxt = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ovf     <= 1'b0;
      tx_req  <= 1'b0;
      tx_data <= '0;
      tmo_cnt <= '0;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);

      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      end

      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;

      tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (do_pop) begin
            tx_data <= mem[rd_ptr];
            tx_req  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        // A core that never answers releases the engine after four quiet cycles; the byte is not retried.
        WAIT_BUSY: begin
          if (tx_busy)
            state <= WAIT_DONE;
          else if (tmo_cnt == 2'd3)
            state <= IDLE;
          else
            tmo_cnt <= tmo_cnt + 2'd1;
        end
        WAIT_DONE: begin
          if (!tx_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: directed pushes feed an expected-byte queue,
// a monitor checks every tx_req against it; a small core model drives tx_busy.
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic       ovf;
  logic       ovf_clr;
  logic       run;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       flush;

  int checks = 0;
  int fails  = 0;
  int req_count = 0;
  logic [7:0] exp_q [$];

  bit core_en  = 1'b1;
  int busy_len = 3;

  uart_tx_queue #(.DEPTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .level   (level),
    .ovf     (ovf),
    .ovf_clr (ovf_clr),
    .run     (run),
    .tx_req  (tx_req),
    .tx_data (tx_data),
`ifdef UART_TXQ_FLUSH_EN
    .flush   (flush),
`endif
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: samples tx_req, raises busy one cycle later for busy_len cycles.
  initial begin : core_model
    int  cnt;
    bit  pending;
    cnt = 0;
    pending = 1'b0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        tx_busy = 1'b0;
        cnt = 0;
        pending = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) tx_busy = 1'b0;
        end else if (pending) begin
          tx_busy = 1'b1;
          cnt = busy_len;
          pending = 1'b0;
        end
        if (tx_req && core_en) pending = 1'b1;
      end
    end
  end

  // Monitor: every request must carry the next expected byte, never overlap busy, never repeat.
  initial begin : monitor
    logic prev_req;
    logic [7:0] e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && tx_req) begin
        req_count++;
        chk("req_not_consecutive", {31'd0, prev_req}, 32'd0);
        chk("req_while_busy", {31'd0, tx_busy}, 32'd0);
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_req: got tx_data 0x%0h, expected no request", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            fails++;
            $display("FAIL sb_tx_data: got 0x%0h, expected 0x%0h", tx_data, e);
          end
        end
      end
      prev_req = rst ? 1'b0 : tx_req;
    end
  end

  task automatic push(input logic [7:0] b, input bit accept);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic push_end;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while (!(empty && !tx_busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_bound", {31'd0, (n >= 500)}, 32'd0);
    repeat (12) @(posedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
  endtask

  task automatic summary;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    fails++;
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int rc0;
    int nreq;
    int first_req;
    int gap;
    int last;
    int n;

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0; run = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // Single byte: request two edges after the push.
    run = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    chk("single_level_1", level, 1);
    chk("single_req_early", tx_req, 0);
    chk("single_empty_0", empty, 0);
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1;
    chk("single_req", tx_req, 1);
    chk("single_data", tx_data, 8'hA5);
    chk("single_level_0", level, 0);
    @(posedge clk); #1;
    chk("single_req_pulse", tx_req, 0);
    wait_drain();

    // Burst of 8 fills the queue, then drains in order.
    @(negedge clk); run = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i), 1'b1);
    push_end();
    chk("burst_full", full, 1);
    chk("burst_level", level, 8);
    rc0 = req_count;
    run = 1'b1;
    wait_drain();
    chk("burst_req_count", req_count - rc0, 8);

    // Overflow: ninth byte dropped; set beats clear.
    @(negedge clk); run = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i), (i < 8));
    push_end();
    chk("ovf_set", ovf, 1);
    chk("ovf_level", level, 8);
    chk("ovf_full", full, 1);
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h19;
    @(negedge clk); ovf_clr = 1'b0; wr_en = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);
    rc0 = req_count;
    run = 1'b1;
    wait_drain();
    chk("ovf_drain_count", req_count - rc0, 8);

    // Push into a full queue during the pop cycle is rejected; later pushes wrap.
    @(negedge clk); run = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b1);
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hEE; run = 1'b1;
    @(posedge clk); #1;
    chk("simul_level", level, 7);
    chk("simul_ovf", ovf, 1);
    chk("simul_req", tx_req, 1);
    @(negedge clk); wr_en = 1'b0; run = 1'b0; ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("simul_ovf_clr", ovf, 0);
    push(8'h28, 1'b1);
    push_end();
    chk("wrap_level", level, 8);
    run = 1'b1;
    wait_drain();

    // Timeout: core never goes busy; requests every 6 cycles.
    core_en = 1'b0;
    @(negedge clk); run = 1'b0;
    push(8'h30, 1'b1);
    push(8'h31, 1'b1);
    push_end();
    run = 1'b1;
    nreq = 0; first_req = -1; gap = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (tx_req) begin
        if (nreq == 0) first_req = c;
        else if (nreq == 1) gap = c - last;
        last = c;
        nreq++;
      end
    end
    chk("tmo_req_count", nreq, 2);
    chk("tmo_first_req", first_req, 0);
    chk("tmo_gap", gap, 6);
    chk("tmo_empty", empty, 1);
    chk("tmo_sb", exp_q.size(), 0);
    core_en = 1'b1;

    // Reset while in WAIT_DONE with three bytes still queued.
    busy_len = 10;
    @(negedge clk); run = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i), 1'b1);
    push_end();
    run = 1'b1;
    n = 0;
    while (!tx_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rstmid_busy_bound", {31'd0, (n >= 50)}, 32'd0);
    @(posedge clk); #1;
    chk("rstmid_level_pre", level, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_level", level, 0);
    chk("rstmid_empty", empty, 1);
    chk("rstmid_tx_req", tx_req, 0);
    chk("rstmid_full", full, 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    busy_len = 3;
    repeat (4) @(posedge clk);
    #1;
    chk("rstmid_idle_req", tx_req, 0);

`ifdef UART_TXQ_FLUSH_EN
    // Flush beats a same-cycle push and leaves ovf alone.
    @(negedge clk); run = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i), 1'b0);
    push_end();
    chk("flush_level_pre", level, 5);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk); flush = 1'b0; wr_en = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", ovf, 0);
    push(8'h56, 1'b1);
    push_end();
    run = 1'b1;
    wait_drain();
`endif

    chk("sb_final_empty", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule
